k16_front_panel: RTL
====================

# k16_front_panel

Panel-side endpoint of the K16 time-multiplexed front-panel link. It receives the scanned `io_clk`/`io_addr`/`io_leds` stream from the CPU I/O block and rebuilds the 16-bit address and data LED words, committing them tear-free once per frame. It also debounces the 32 physical panel switches and drives the matching `io_switches` nibble back for each scan slot. It sits in the panel FPGA/CPLD between the ribbon link and the physical LEDs and switches.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `io_clk`, `io_addr` and `io_leds`; minimum 2.
- `DEBOUNCE_CYCLES`, 250000: `clk` cycles between debounce sample ticks; minimum 2.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `io_clk`  in  1  scan clock from CPU side; asynchronous to `clk` and much slower.
- `io_addr`  in  3  scan slot; the CPU side increments it on each rising `io_clk` edge.
- `io_leds`  in  4  LED nibble; updated on rising `io_clk` edge with the nibble for slot `io_addr-1`.
- `io_switches`  out  4  switch nibble for the current slot; the CPU side samples it on rising `io_clk` edge.
- `addr_sw`  in  16  raw physical address switches, active-high.
- `ctrl_sw`  in  16  raw physical control switches, active-high.
- `led_addr`  out  16  committed address LED word.
- `led_data`  out  16  committed data LED word.
- `locked`  out  1  a full in-order frame has been seen since the last error or reset.
- `frame_sync`  out  1  one-cycle pulse when LED words are committed.
- `seq_error`  out  1  one-cycle pulse on an out-of-order `io_addr`.

## Operation
- **Synchronizers.** `io_clk`, `io_addr` and `io_leds` each pass through `SYNC_STAGES` flops.
- **Edge detection.** Comparing synced `io_clk` with its one-cycle-delayed copy gives `rise` and `fall` strobes, each one `clk` wide.
- **Capture on `fall`.** `slot = synced io_addr - 1` (mod 8). Shadow nibble `slot` is written with synced `io_leds`.
  - Slots 0..3 map to shadow_addr[3:0] .. [15:12].
  - Slots 4..7 map to shadow_data[3:0] .. [15:12].
- **Sequence check on `rise`.** The new synced `io_addr` must equal `prev_addr+1` (mod 8).
  - Mismatch while `locked`=1: pulse `seq_error`, clear `locked` and the run counter.
  - Mismatch while `locked`=0: restart the run.
  - `prev_addr` is always updated.
  - The first `rise` after reset only loads `prev_addr` and is never an error.
- **Lock.** A 3-bit run counter counts consecutive in-order rises and saturates at 7. `locked` goes to 1 when it reaches 7 on a rise where synced `io_addr`=0.
- **Commit.** On a `fall` that captures slot 7 with `locked`=1, `{led_data, led_addr}` are loaded from the shadow registers, with the slot-7 nibble bypassed in on that same cycle, and `frame_sync` pulses.
  - No commit while unlocked; LEDs hold their last values.
- **Switch return.** On each `fall`, `io_switches` is loaded for slot = synced `io_addr`:
  - Slots 0..3: the matching debounced `addr_sw` nibble.
  - Slots 4..7: the bitwise inverse of the matching debounced `ctrl_sw` nibble (the link is active-low for control).
- **Debounce.**
  - A shared counter produces `tick` every `DEBOUNCE_CYCLES` clocks.
  - On `tick`, each of the 32 switches shifts its raw value into a 2-bit history.
  - The debounced bit takes the raw value when raw equals both history bits, i.e. three agreeing samples.

## Timing
- Reset values:
  - `io_switches`=4'hF (all control inputs released).
  - `led_addr`=`led_data`=0, `locked`=0, `frame_sync`=0, `seq_error`=0.
  - Shadows, histories, debounced switch state, `prev_addr`, run counter and tick counter are all 0.
- Edge-strobe latency: `SYNC_STAGES`+1 `clk` cycles after the pin edge.
- Commit and `frame_sync` occur in the cycle after the slot-7 `fall` strobe. LED outputs change only there.
- `io_switches` is registered on `fall`, so it is stable for the entire low phase of `io_clk` and through the next rising edge.
- Debounce latency: a clean switch change appears 2–3 ticks after the change.
- If `rise` and `tick` occur in the same cycle, both are processed independently. `rise` and `fall` can never coincide.
- `reset` asserted mid-frame returns everything to reset values on the next `clk` edge. Shadow contents are discarded, and re-lock needs a fresh full frame.
- `io_addr` wraps from 7 to 0 as a legal in-order step.

## Test plan
- **Clean stream, first frame.** After reset, send 9 in-order slots carrying LED words addr=16'hA5C3, data=16'h1234 -> `locked`=1. At the first qualifying slot-7 `fall`: `led_addr`=16'hA5C3, `led_data`=16'h1234, one `frame_sync` pulse.
- **Mid-frame change.** Change `io_leds` mid-frame, with slots 0..3 new and 4..7 old -> LEDs unchanged until the slot-7 `fall`, then the whole new word appears in one cycle.
- **Switch return.** Set `addr_sw`=16'hBEEF, `ctrl_sw`=16'h0005, held >3 ticks -> `io_switches`:
  - Slots 0..3: F, E, E, B.
  - Slots 4..7: A, F, F, F.
- **Bounce rejection.** Toggle `ctrl_sw[3]` every tick for 10 ticks, then hold it at 1 -> the debounced bit stays 0 while toggling, then goes 1 on the 3rd agreeing tick.
- **Sequence error.** While locked, jump `io_addr` from 2 to 5 -> one `seq_error` pulse, `locked`=0, no commit until a full in-order frame has been re-observed.
- **Reset mid-frame.** Assert `reset` for 1 cycle at slot 4 -> all outputs return to reset values, `io_switches`=4'hF, no `seq_error` on the following rise.

Source files
------------

// File: rtl/k16_front_panel.sv
// k16_front_panel: panel-side endpoint of the K16 scanned front-panel link.
// Rebuilds the LED words once per frame and returns debounced switch nibbles.
module k16_front_panel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_clk,
    input  logic [2:0]  io_addr,
    input  logic [3:0]  io_leds,
    output logic [3:0]  io_switches,
    input  logic [15:0] addr_sw,
    input  logic [15:0] ctrl_sw,
    output logic [15:0] led_addr,
    output logic [15:0] led_data,
    output logic        locked,
    output logic        frame_sync,
    output logic        seq_error
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0]      clk_sync;
    logic [SYNC_STAGES-1:0][2:0] addr_sync;
    logic [SYNC_STAGES-1:0][3:0] leds_sync;

    logic       s_clk;
    logic       clk_d;
    logic       rise;
    logic       fall;
    logic [2:0] s_addr;
    logic [3:0] s_leds;

    assign s_clk  = clk_sync[SYNC_STAGES-1];
    assign s_addr = addr_sync[SYNC_STAGES-1];
    assign s_leds = leds_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '0;
            addr_sync <= '0;
            leds_sync <= '0;
            clk_d     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], io_clk};
            addr_sync <= {addr_sync[SYNC_STAGES-2:0], io_addr};
            leds_sync <= {leds_sync[SYNC_STAGES-2:0], io_leds};
            clk_d     <= s_clk;
            rise      <= s_clk & ~clk_d;
            fall      <= ~s_clk & clk_d;
        end
    end

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [31:0]   raw;
    logic [31:0]   hist0;
    logic [31:0]   hist1;
    logic [31:0]   db;
    logic [31:0]   agree1;
    logic [31:0]   agree0;
    logic [15:0]   addr_db;
    logic [15:0]   ctrl_db;

    assign raw    = {ctrl_sw, addr_sw};
    assign tick   = (tick_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign agree1 = raw & hist0 & hist1;
    assign agree0 = ~(raw | hist0 | hist1);
    assign {ctrl_db, addr_db} = db;

    // a bit only moves once three consecutive tick samples agree
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            hist0    <= '0;
            hist1    <= '0;
            db       <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            if (tick) begin
                hist0 <= raw;
                hist1 <= hist0;
                db    <= agree1 | (db & ~agree0);
            end
        end
    end

    logic [2:0]  cap_slot;
    logic [2:0]  prev_addr;
    logic [2:0]  run_cnt;
    logic [2:0]  run_inc;
    logic        primed;
    logic        addr_ok;
    logic        commit;
    logic [31:0] shadow;
    logic [31:0] shadow_nxt;
    logic [3:0]  sw_nxt;

    assign cap_slot = s_addr - 3'd1;
    assign addr_ok  = (s_addr == prev_addr + 3'd1);
    assign run_inc  = (run_cnt == 3'd7) ? 3'd7 : run_cnt + 3'd1;
    assign commit   = fall && (cap_slot == 3'd7) && locked;

    // slot-7 nibble is bypassed so the commit sees the whole frame
    always_comb begin
        shadow_nxt = shadow;
        if (fall) begin
            shadow_nxt[{cap_slot, 2'b00} +: 4] = s_leds;
        end
    end

    always_comb begin
        sw_nxt = addr_db[{s_addr[1:0], 2'b00} +: 4];
        if (s_addr[2]) begin
            sw_nxt = ~ctrl_db[{s_addr[1:0], 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= '0;
            led_addr    <= '0;
            led_data    <= '0;
            frame_sync  <= 1'b0;
            seq_error   <= 1'b0;
            locked      <= 1'b0;
            prev_addr   <= '0;
            run_cnt     <= '0;
            primed      <= 1'b0;
            io_switches <= 4'hF;
        end else begin
            shadow     <= shadow_nxt;
            frame_sync <= commit;
            seq_error  <= 1'b0;
            if (commit) begin
                {led_data, led_addr} <= shadow_nxt;
            end
            if (fall) begin
                io_switches <= sw_nxt;
            end
            if (rise) begin
                prev_addr <= s_addr;
                primed    <= 1'b1;
                if (primed && addr_ok) begin
                    run_cnt <= run_inc;
                    if (run_inc == 3'd7 && s_addr == 3'd0) begin
                        locked <= 1'b1;
                    end
                end else if (primed) begin
                    run_cnt <= 3'd0;
                    if (locked) begin
                        seq_error <= 1'b1;
                        locked    <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
